accum_32b: RTL and testbench
============================

ACCUM_32B -- requirements
Module: accum_32b

Interface
REQ-001 Parameter: CNT_W, default 8, width of the operand-count output.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand present on in_data.
REQ-005 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-006 Port: in_data  input  32  unsigned operand, the sum-stage input word.
REQ-007 Port: in_last  input  1  marks the final operand of a sequence; sampled only on accept.
REQ-008 Port: out_valid  output  1  result available.
REQ-009 Port: out_ready  input  1  downstream consumes the result.
REQ-010 Port: out_sum  output  32  accumulated sum modulo 2^32.
REQ-011 Port: out_carry  output  1  sticky carry-out: set if any addition in the sequence overflowed 32 bits.
REQ-012 Port: out_count  output  CNT_W  number of operands accepted in the sequence, saturating.

Function
REQ-013 Accept = in_valid && in_ready, evaluated at the rising edge of clk.
REQ-014 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; it is a function of state only, not of in_valid.
REQ-016 IDLE, accept: acc <= in_data; carry <= 0; count <= 1; next state DONE if in_last, else ACCUM.
REQ-017 IDLE, no accept: hold the state and all registers.
REQ-018 ACCUM, accept: {c, acc} <= acc + in_data (33-bit sum); carry <= carry | c; count <= count + 1; next state DONE if in_last, else ACCUM.
REQ-019 ACCUM, no accept: hold the state and all registers; there is no timeout.
REQ-020 count SHALL saturate at 2^CNT_W-1; further accepts leave it unchanged, and the sum and carry still update.
REQ-021 DONE: out_valid = 1; out_sum, out_carry and out_count SHALL equal acc, carry and count, and SHALL remain stable until the handshake completes.
REQ-022 DONE with out_ready = 1: next state IDLE; out_valid is 0 in the following cycle.
REQ-023 In DONE, in_valid SHALL be ignored; no operand is accepted in the cycle the result is consumed, so the minimum sequence period is 2 cycles for a 1-operand sequence.
REQ-024 out_valid SHALL be 0 in IDLE and ACCUM; out_sum, out_carry and out_count show the internal registers there but carry no meaning.
REQ-025 Latency: the result is valid in the cycle after the accept that carries in_last.
REQ-026 Wrap-around: the sum is modulo 2^32 with no saturation; overflow is reported only through out_carry.

Reset
REQ-027 reset = 1 SHALL immediately, without waiting for clk, force state to IDLE, acc to 0, carry to 0, count to 0, and out_valid to 0; in_ready = 1 while reset is deasserted in IDLE.
REQ-028 Reset asserted mid-sequence (ACCUM) or with a pending result (DONE) SHALL discard the partial or pending result; the first accept after reset starts a new sequence.
REQ-029 in_ready SHALL be 0 while reset is asserted.

Verification
REQ-030 Single operand: accept 0x0000_0005 with in_last -> next cycle out_valid=1, out_sum=0x0000_0005, out_carry=0, out_count=1.
REQ-031 Overflow: operands 0xFFFF_FFFF, 0x0000_0002 (last) -> out_sum=0x0000_0001, out_carry=1, out_count=2; a following sequence of 1, 1 (last) -> out_sum=2, out_carry=0.
REQ-032 Backpressure: result held with out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0, outputs stable, no operand consumed; out_ready=1 -> IDLE, next operand accepted 1 cycle later.
REQ-033 Bubbles: 3 operands 10, 20, 30 (last) with in_valid gaps of 0, 2 and 4 cycles -> out_sum=60, out_count=3.
REQ-034 Saturation (CNT_W=8): 300 operands of value 1 -> out_count=255, out_sum=300 (0x12C), out_carry=0.
REQ-035 Async reset: assert reset between clock edges during ACCUM after 2 operands -> out_valid=0 and in_ready=0 at once; after release, a 1-operand sequence of 7 -> out_sum=7, out_count=1.

Source files
------------

// File: rtl/accum_32b.sv
// Streaming 32-bit accumulator: sums a sequence of operands terminated by in_last
// and presents sum, sticky carry and saturating operand count as one result.
module accum_32b #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state;
  logic [31:0]      acc;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [32:0]      sum_ext;
  logic             accept;

  // in_ready depends on state only; reset masks it so nothing is taken while held
  assign in_ready = !reset && (state != StDone);
  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, acc} + {1'b0, in_data};

  assign out_valid = (state == StDone);
  assign out_sum   = acc;
  assign out_carry = carry;
  assign out_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            acc   <= in_data;
            carry <= 1'b0;
            count <= CntOne;
            state <= in_last ? StDone : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            acc   <= sum_ext[31:0];
            carry <= carry | sum_ext[32];
            if (count != CntMax) count <= count + CntOne;
            state <= in_last ? StDone : StAccum;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_32b.sv
// Directed self-checking bench for accum_32b with hand-computed expectations.
module tb_accum_32b;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  accum_32b #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] sum, input logic c,
                        input logic [7:0] cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   out_sum, sum);
    chk({tag, "_carry"}, 32'(out_carry), 32'(c));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready_held", 32'(in_ready), 32'd0);
    chk("rst_out_valid_held", 32'(out_valid), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);

    // Single operand
    send(32'h0000_0005, 1'b1);
    result("single", 32'h5, 1'b0, 8'd1);
    chk("single_in_ready", 32'(in_ready), 32'd0);
    consume("single");

    // Overflow, then a clean sequence must clear carry
    send(32'hFFFF_FFFF, 1'b0);
    chk("ovf_mid_valid", 32'(out_valid), 32'd0);
    send(32'h0000_0002, 1'b1);
    result("ovf", 32'h1, 1'b1, 8'd2);
    consume("ovf");
    send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    result("after_ovf", 32'd2, 1'b0, 8'd2);
    consume("after_ovf");

    // Backpressure with in_valid held high
    send(32'd9, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      result("bp_hold", 32'd9, 1'b0, 8'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_released_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    result("bp_next", 32'h55, 1'b0, 8'd1);
    consume("bp_next");

    // Bubbles: gaps of 0, 2 and 4 cycles
    send(32'd10, 1'b0);
    step();
    step();
    chk("bub_gap_valid", 32'(out_valid), 32'd0);
    send(32'd20, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("bub_gap2_valid", 32'(out_valid), 32'd0);
    chk("bub_gap2_ready", 32'(in_ready), 32'd1);
    send(32'd30, 1'b1);
    result("bubbles", 32'd60, 1'b0, 8'd3);
    consume("bubbles");

    // Count saturation
    for (int i = 0; i < 299; i++) send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    result("sat", 32'h12C, 1'b0, 8'd255);
    consume("sat");

    // Async reset in ACCUM, between clock edges
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_accum_valid", 32'(out_valid), 32'd0);
    chk("arst_accum_ready", 32'(in_ready), 32'd0);
    chk("arst_accum_sum", out_sum, 32'd0);
    chk("arst_accum_count", 32'(out_count), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    send(32'd7, 1'b1);
    result("arst_new", 32'd7, 1'b0, 8'd1);

    // Async reset with a pending result in DONE
    #2;
    reset = 1'b1;
    #1;
    chk("arst_done_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0;
    #1;
    send(32'd2, 1'b1);
    result("arst_done_new", 32'd2, 1'b0, 8'd1);
    consume("arst_done_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
